commit_trace_buffer: RTL and testbench

- Synthesizable retire-trace capture for the pipelined processor.
- Classifies each committed instruction, numbers it, counts instructions and cycles, and buffers the records in a parametrised FIFO.
- A valid/ready port drains the FIFO to a trace sink (bench or debug port).
- On halt, emits a halt record, drains, then asserts done and freezes the counters.

---
 rtl/commit_trace_buffer.sv | 211 +++++++++++++++++++++
 tb/tb_commit_trace_buffer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_buffer.sv
// Retire-trace capture: classifies each committed instruction, numbers it,
// keeps instruction/cycle/drop counters and buffers records in a FIFO that a
// valid/ready sink drains. A HALT commit is always recorded, after which the
// FIFO drains and the block parks in DONE with its counters frozen.
//
// Sink handshake: rec_valid is high whenever the FIFO holds a record and the
// rec_* fields show the head. A record is consumed on any clock edge where
// rec_valid && rec_ready. rec_valid never drops without a transfer except on
// reset. rec_ready may toggle freely.
module commit_trace_buffer #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_valid,
    input  logic [DATA_W-1:0] commit_pc,
    input  logic              reg_write,
    input  logic [REG_W-1:0]  write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              halt,
    input  logic              rec_ready,
    output logic              rec_valid,
    output logic [2:0]        rec_kind,
    output logic [CNT_W-1:0]  rec_inum,
    output logic [DATA_W-1:0] rec_pc,
    output logic [REG_W-1:0]  rec_reg,
    output logic [DATA_W-1:0] rec_wdata,
    output logic [DATA_W-1:0] rec_addr,
    output logic [DATA_W-1:0] rec_mdata,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  drop_count,
    output logic              overflow,
    output logic              done,
    output logic [1:0]        dbg_state_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_PEND = 2'd1,
        ST_DRAIN     = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0]        kind;
        logic [CNT_W-1:0]  inum;
        logic [DATA_W-1:0] pc;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] mdata;
    } rec_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    state_t            state_q, state_d;
    rec_t              mem_q [DEPTH];
    rec_t              pend_q, pend_d;
    rec_t              new_rec, push_rec, head;
    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fifo_count;
    logic [CNT_W-1:0]  inst_q, inst_d, cycle_q, cycle_d, drop_q, drop_d;
    logic              ovf_q, ovf_d;
    logic              push, pop, full, space;

    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign full       = (fifo_count == (AW+1)'(DEPTH));
    assign rec_valid  = (fifo_count != '0);
    assign pop        = rec_valid && rec_ready;
    // A full FIFO still has room this cycle if the head leaves at the same edge.
    assign space      = !full || pop;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    // Build the record for the retiring instruction; unused fields stay zero.
    always_comb begin
        new_rec      = '0;
        new_rec.inum = inst_q;
        new_rec.pc   = commit_pc;
        if (halt) begin
            new_rec.kind = 3'd5;
        end else if (reg_write && mem_write) begin
            new_rec.kind  = 3'd4;
            new_rec.rd    = write_reg;
            new_rec.wdata = write_data;
            new_rec.addr  = mem_addr;
            new_rec.mdata = mem_data;
        end else if (mem_write) begin
            new_rec.kind  = 3'd3;
            new_rec.addr  = mem_addr;
            new_rec.mdata = mem_data;
        end else if (reg_write && mem_read) begin
            new_rec.kind  = 3'd2;
            new_rec.rd    = write_reg;
            new_rec.wdata = write_data;
            new_rec.addr  = mem_addr;
        end else if (reg_write) begin
            new_rec.kind  = 3'd1;
            new_rec.rd    = write_reg;
            new_rec.wdata = write_data;
        end else begin
            new_rec.kind = 3'd0;
        end
    end

    // Next-state logic: FSM, push decision, counters and FIFO pointers.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        push     = 1'b0;
        push_rec = new_rec;
        inst_d   = inst_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_RUN: begin
                if (commit_valid) begin
                    inst_d = sat_inc(inst_q);
                    if (halt) begin
                        if (space) begin
                            push    = 1'b1;
                            state_d = ST_DRAIN;
                        end else begin
                            pend_d  = new_rec;
                            state_d = ST_HALT_PEND;
                        end
                    end else if (space) begin
                        push = 1'b1;
                    end else begin
                        drop_d = sat_inc(drop_q);
                        ovf_d  = 1'b1;
                    end
                end
            end
            ST_HALT_PEND: begin
                if (space) begin
                    push     = 1'b1;
                    push_rec = pend_q;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_count == (AW+1)'(pop)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_DONE;
            end
        endcase
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        cycle_d  = (state_q == ST_DONE) ? cycle_q : sat_inc(cycle_q);
    end

    // Control and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            pend_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            inst_q   <= '0;
            cycle_q  <= '0;
            drop_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            inst_q   <= inst_d;
            cycle_q  <= cycle_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_rec;
        end
    end

    assign rec_kind    = rec_valid ? head.kind  : '0;
    assign rec_inum    = rec_valid ? head.inum  : '0;
    assign rec_pc      = rec_valid ? head.pc    : '0;
    assign rec_reg     = rec_valid ? head.rd    : '0;
    assign rec_wdata   = rec_valid ? head.wdata : '0;
    assign rec_addr    = rec_valid ? head.addr  : '0;
    assign rec_mdata   = rec_valid ? head.mdata : '0;
    assign inst_count  = inst_q;
    assign cycle_count = cycle_q;
    assign drop_count  = drop_q;
    assign overflow    = ovf_q;
    assign done        = (state_q == ST_DONE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer with hand-computed expectations.
module tb_commit_trace_buffer;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 32;

    localparam logic [1:0] S_RUN = 2'd0, S_PEND = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              commit_valid = 1'b0;
    logic [DATA_W-1:0] commit_pc = '0;
    logic              reg_write = 1'b0;
    logic [REG_W-1:0]  write_reg = '0;
    logic [DATA_W-1:0] write_data = '0;
    logic              mem_read = 1'b0;
    logic              mem_write = 1'b0;
    logic [DATA_W-1:0] mem_addr = '0;
    logic [DATA_W-1:0] mem_data = '0;
    logic              halt = 1'b0;
    logic              rec_ready = 1'b0;
    logic              rec_valid;
    logic [2:0]        rec_kind;
    logic [CNT_W-1:0]  rec_inum;
    logic [DATA_W-1:0] rec_pc;
    logic [REG_W-1:0]  rec_reg;
    logic [DATA_W-1:0] rec_wdata;
    logic [DATA_W-1:0] rec_addr;
    logic [DATA_W-1:0] rec_mdata;
    logic [CNT_W-1:0]  inst_count;
    logic [CNT_W-1:0]  cycle_count;
    logic [CNT_W-1:0]  drop_count;
    logic              overflow;
    logic              done;
    logic [1:0]        dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cyc  = 0;
    bit exp_done = 1'b0;
    logic [CNT_W-1:0] exp_q[$];

    commit_trace_buffer #(
        .DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data(mem_data), .halt(halt), .rec_ready(rec_ready),
        .rec_valid(rec_valid), .rec_kind(rec_kind), .rec_inum(rec_inum),
        .rec_pc(rec_pc), .rec_reg(rec_reg), .rec_wdata(rec_wdata),
        .rec_addr(rec_addr), .rec_mdata(rec_mdata), .inst_count(inst_count),
        .cycle_count(cycle_count), .drop_count(drop_count), .overflow(overflow),
        .done(done), .dbg_state_o(dbg_state_o)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // Advance one clock; the expected cycle counter follows the reset/DONE rules.
    task automatic tick();
        @(posedge clk);
        if (!rst) exp_cyc = 0;
        else if (!exp_done) exp_cyc++;
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        commit_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        exp_done = 1'b0;
    endtask

    // One-cycle commit; the remaining inputs are left with junk-free zeros after.
    task automatic commit(input logic [DATA_W-1:0] pc, input logic rw, input logic [REG_W-1:0] wr,
                          input logic [DATA_W-1:0] wd, input logic mr, input logic mw,
                          input logic [DATA_W-1:0] ma, input logic [DATA_W-1:0] md, input logic h);
        commit_valid = 1'b1;
        commit_pc = pc; reg_write = rw; write_reg = wr; write_data = wd;
        mem_read = mr; mem_write = mw; mem_addr = ma; mem_data = md; halt = h;
        tick();
        commit_valid = 1'b0;
        commit_pc = '0; reg_write = 1'b0; write_reg = '0; write_data = '0;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_data = '0; halt = 1'b0;
    endtask

    initial begin
        int n;
        logic [CNT_W-1:0] last_inum;
        logic [2:0]       last_kind;
        logic [DATA_W-1:0] last_pc;

        // Reset state
        do_reset();
        check("rst_valid", rec_valid, 0);
        check("rst_inst", inst_count, 0);
        check("rst_cycle", cycle_count, 0);
        check("rst_drop", drop_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_done", done, 0);
        check("rst_kind", rec_kind, 0);
        check("rst_state", dbg_state_o, S_RUN);

        // Single REG commit visible the cycle after its edge
        rec_ready = 1'b1;
        commit(16'h0000, 1, 3'd3, 16'h1234, 0, 0, 16'h0000, 16'h0000, 0);
        check("t1_valid", rec_valid, 1);
        check("t1_kind", rec_kind, 1);
        check("t1_inum", rec_inum, 0);
        check("t1_reg", rec_reg, 3);
        check("t1_wdata", rec_wdata, 16'h1234);
        check("t1_addr", rec_addr, 0);
        check("t1_inst", inst_count, 1);
        check("t1_cycle", cycle_count, exp_cyc);
        tick();
        check("t1_empty", rec_valid, 0);

        // LD / ST / STU / NOP classification and zeroing of unused fields
        do_reset();
        rec_ready = 1'b0;
        commit(16'h0004, 1, 3'd2, 16'h00AA, 1, 0, 16'h0040, 16'h7777, 0);
        commit(16'h0008, 0, 3'd5, 16'h9999, 0, 1, 16'h0042, 16'h5555, 0);
        commit(16'h000C, 1, 3'd1, 16'h1111, 0, 1, 16'h0044, 16'h2222, 0);
        commit(16'h0010, 0, 3'd6, 16'h3333, 1, 0, 16'h0048, 16'h4444, 0);
        check("ld_kind", rec_kind, 2);
        check("ld_inum", rec_inum, 0);
        check("ld_reg", rec_reg, 2);
        check("ld_wdata", rec_wdata, 16'h00AA);
        check("ld_addr", rec_addr, 16'h0040);
        check("ld_mdata", rec_mdata, 0);
        rec_ready = 1'b1;
        tick();
        check("st_kind", rec_kind, 3);
        check("st_inum", rec_inum, 1);
        check("st_pc", rec_pc, 16'h0008);
        check("st_reg", rec_reg, 0);
        check("st_wdata", rec_wdata, 0);
        check("st_addr", rec_addr, 16'h0042);
        check("st_mdata", rec_mdata, 16'h5555);
        tick();
        check("stu_kind", rec_kind, 4);
        check("stu_inum", rec_inum, 2);
        check("stu_reg", rec_reg, 1);
        check("stu_wdata", rec_wdata, 16'h1111);
        check("stu_addr", rec_addr, 16'h0044);
        check("stu_mdata", rec_mdata, 16'h2222);
        tick();
        check("nop_kind", rec_kind, 0);
        check("nop_inum", rec_inum, 3);
        check("nop_pc", rec_pc, 16'h0010);
        check("nop_addr", rec_addr, 0);
        check("nop_reg", rec_reg, 0);
        tick();
        check("t2_empty", rec_valid, 0);

        // Overflow: 10 commits into 8 slots with the sink stalled
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            commit(16'(i * 2), 1, 3'(i), 16'(16'h0100 + i), 0, 0, 16'h0, 16'h0, 0);
            if (i < DEPTH) exp_q.push_back(CNT_W'(i));
        end
        check("ovf_drop", drop_count, 2);
        check("ovf_flag", overflow, 1);
        check("ovf_inst", inst_count, 10);
        check("ovf_state", dbg_state_o, S_RUN);
        rec_ready = 1'b1;
        for (int g = 0; g < 20 && exp_q.size() > 0; g++) begin
            if (!rec_valid) begin
                check("ovf_drain_valid", rec_valid, 1);
                break;
            end
            check("ovf_drain_inum", rec_inum, exp_q[0]);
            check("ovf_drain_pc", rec_pc, 64'(exp_q[0]) * 2);
            void'(exp_q.pop_front());
            tick();
        end
        check("ovf_drain_left", exp_q.size(), 0);
        check("ovf_drain_empty", rec_valid, 0);
        exp_q.delete();

        // Full FIFO with simultaneous commit and pop: no drop, 8 stay buffered
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            commit(16'(i * 2), 1, 3'd1, 16'(i), 0, 0, 16'h0, 16'h0, 0);
        rec_ready = 1'b1;
        commit(16'h0100, 1, 3'd4, 16'hBEEF, 0, 0, 16'h0, 16'h0, 0);
        check("fp_drop", drop_count, 0);
        check("fp_ovf", overflow, 0);
        check("fp_head", rec_inum, 1);
        n = 0;
        last_inum = '0;
        for (int g = 0; g < 20 && rec_valid; g++) begin
            last_inum = rec_inum;
            n++;
            tick();
        end
        check("fp_occupancy", n, 8);
        check("fp_last_inum", last_inum, 8);

        // Halt while full: held pending, never dropped, last out, then DONE
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            commit(16'(i * 4), 1, 3'd2, 16'(i), 0, 0, 16'h0, 16'h0, 0);
        commit(16'h0020, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
        check("hp_state", dbg_state_o, S_PEND);
        check("hp_drop", drop_count, 0);
        check("hp_ovf", overflow, 0);
        check("hp_inst", inst_count, 9);
        commit(16'h0030, 1, 3'd7, 16'h7, 0, 0, 16'h0, 16'h0, 0);
        check("hp_ignored_inst", inst_count, 9);
        check("hp_state2", dbg_state_o, S_PEND);
        rec_ready = 1'b1;
        n = 0;
        last_kind = '0;
        last_pc = '0;
        last_inum = '0;
        for (int k = 0; k < 9; k++) begin
            if (rec_valid) begin
                last_kind = rec_kind;
                last_pc = rec_pc;
                last_inum = rec_inum;
                n++;
            end
            if (k == 8) check("hp_not_done_early", done, 0);
            tick();
        end
        exp_done = 1'b1;
        check("hp_pops", n, 9);
        check("hp_last_kind", last_kind, 5);
        check("hp_last_pc", last_pc, 16'h0020);
        check("hp_last_inum", last_inum, 8);
        check("hp_done", done, 1);
        check("hp_state_done", dbg_state_o, S_DONE);
        check("hp_empty", rec_valid, 0);
        check("hp_cycle", cycle_count, exp_cyc);
        commit(16'h0040, 1, 3'd1, 16'h1, 0, 0, 16'h0, 16'h0, 0);
        tick();
        tick();
        check("hp_cycle_frozen", cycle_count, 19);
        check("hp_done_inst", inst_count, 9);
        check("hp_done_valid", rec_valid, 0);
        check("hp_done_hold", done, 1);

        // Reset mid-drain discards the buffered records and the counters
        do_reset();
        rec_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            commit(16'(i), 1, 3'd1, 16'(i), 0, 0, 16'h0, 16'h0, 0);
        commit(16'h0022, 0, 3'd0, 16'h0, 0, 0, 16'h0, 16'h0, 1);
        check("rd_state", dbg_state_o, S_DRAIN);
        commit(16'h0024, 1, 3'd1, 16'h5, 0, 0, 16'h0, 16'h0, 0);
        check("rd_ignored_inst", inst_count, 4);
        check("rd_valid", rec_valid, 1);
        rst = 1'b0;
        tick();
        check("rd_rst_valid", rec_valid, 0);
        check("rd_rst_inst", inst_count, 0);
        check("rd_rst_cycle", cycle_count, 0);
        check("rd_rst_drop", drop_count, 0);
        check("rd_rst_done", done, 0);
        check("rd_rst_state", dbg_state_o, S_RUN);
        check("rd_rst_pc", rec_pc, 0);
        rst = 1'b1;
        rec_ready = 1'b1;
        commit(16'h0050, 1, 3'd6, 16'h00CD, 0, 0, 16'h0, 16'h0, 0);
        check("rd_next_inum", rec_inum, 0);
        check("rd_next_pc", rec_pc, 16'h0050);
        check("rd_next_inst", inst_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
